// File: rtl/nibble_serial_add_ctrl_pkg.sv
// nibble_serial_add_ctrl_pkg: shared FSM states and slice width for the nibble-serial adder
package nibble_serial_add_ctrl_pkg;
    localparam int SLICE_W = 4;
    typedef enum logic [1:0] {IDLE, ADD, DONE} state_e;
endpackage

// File: rtl/nibble_serial_add_ctrl_ripple_adder.sv
// ripple_adder: 4-bit ripple-carry adder built from a chain of full adders
module ripple_adder
    import nibble_serial_add_ctrl_pkg::*;
(
    input  logic [SLICE_W-1:0] a_i,
    input  logic [SLICE_W-1:0] b_i,
    input  logic               c_i,
    output logic [SLICE_W-1:0] s_o,
    output logic               c_o
);
    logic [SLICE_W:0] c;
    assign c[0] = c_i;
    for (genvar i = 0; i < SLICE_W; i++) begin : g_fa
        assign s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
        assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end
    assign c_o = c[SLICE_W];
endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl: adds two W-bit operands one nibble per cycle through a single shared 4-bit adder
module nibble_serial_add_ctrl
    import nibble_serial_add_ctrl_pkg::*;
#(
    parameter int NIBBLES = 4,
    localparam int W = SLICE_W * NIBBLES,
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         Cin,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] S,
    output logic         Cout,
    output logic         Ovf
);
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);
    state_e state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [W-1:0] a_q, a_d, b_q, b_d, s_q, s_d;
    logic c_q, c_d, cout_q, cout_d, ovf_q, ovf_d;
    logic [SLICE_W-1:0] sum;
    logic co;

    ripple_adder u_add (
        .a_i(a_q[idx_q*SLICE_W +: SLICE_W]),
        .b_i(b_q[idx_q*SLICE_W +: SLICE_W]),
        .c_i(c_q),
        .s_o(sum),
        .c_o(co)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        s_d     = s_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: if (start) begin
                a_d     = A;
                b_d     = B;
                c_d     = Cin;
                idx_d   = '0;
                state_d = ADD;
            end
            ADD: begin
                s_d[idx_q*SLICE_W +: SLICE_W] = sum;
                c_d   = co;
                idx_d = idx_q + 1'b1;
                if (idx_q == LAST) begin
                    cout_d  = co;
                    // sum[MSB] of the last slice is the final S[W-1]
                    ovf_d   = (a_q[W-1] == b_q[W-1]) && (sum[SLICE_W-1] != a_q[W-1]);
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy = state_q != IDLE;
    assign done = state_q == DONE;
    assign S    = s_q;
    assign Cout = cout_q;
    assign Ovf  = ovf_q;
endmodule

// File: doc/nibble_serial_add_ctrl.md
NIBBLE_SERIAL_ADD_CTRL -- requirements
Module: nibble_serial_add_ctrl

Interface
REQ-001 Parameter NIBBLES, default 4: number of 4-bit slices per operand; operand width W = 4*NIBBLES.
REQ-002 clk  input  1  rising-edge clock; all state updates on this edge only.
REQ-003 reset  input  1  synchronous, active-high reset; the block has one clock and no other reset.
REQ-004 start  input  1  request to begin an addition; sampled only in IDLE.
REQ-005 A  input  W  operand A; sampled on the accepting edge.
REQ-006 B  input  W  operand B; sampled on the accepting edge.
REQ-007 Cin  input  1  carry-in; sampled on the accepting edge.
REQ-008 busy  output  1  high while an addition is in progress (ADD or DONE state).
REQ-009 done  output  1  one-cycle pulse; S, Cout and Ovf are valid in this cycle.
REQ-010 S  output  W  registered sum.
REQ-011 Cout  output  1  registered carry-out of the most significant slice.
REQ-012 Ovf  output  1  registered two's-complement overflow flag.

Function
REQ-013 The FSM SHALL have three states: IDLE, ADD and DONE.
REQ-014 IDLE with start=1: latch A, B and Cin; clear the slice index to 0; load the carry register with Cin; go to ADD.
REQ-015 IDLE with start=0: remain in IDLE and hold S, Cout and Ovf unchanged.
REQ-016 Each ADD cycle SHALL present latched A and B slice [4*idx+3:4*idx], plus the carry register, to a single shared 4-bit adder.
REQ-017 Each ADD cycle SHALL write the adder sum into S slice idx, load the adder carry-out into the carry register, and increment idx.
REQ-018 ADD with idx = NIBBLES-1: load Cout from the adder carry-out and go to DONE.
REQ-019 On that same edge, Ovf SHALL be loaded with (A[W-1] == B[W-1]) && (final S[W-1] != A[W-1]), using the latched operands.
REQ-020 DONE SHALL assert done for exactly one cycle and then return to IDLE unconditionally.
REQ-021 Latency: with start accepted on edge k, done SHALL be high in the cycle after edge k+NIBBLES; busy SHALL be high from edge k+1 through the done cycle.
REQ-022 start SHALL be ignored in ADD and DONE; there is no queuing, and a dropped request is not remembered.
REQ-023 Changes to A, B or Cin after the accepting edge SHALL NOT affect the result.
REQ-024 S, Cout and Ovf SHALL hold their values after DONE until the next accepted start.
REQ-025 S slices not yet written in the current operation SHALL retain their prior values; only the done cycle guarantees validity.
REQ-026 All arithmetic is unsigned modulo 2^W; Cout is the true carry out of bit W-1.

Reset
REQ-027 While reset=1 on an edge, the FSM SHALL go to IDLE, and idx, the carry register, S, Cout, Ovf, busy and done SHALL be cleared to 0.
REQ-028 Reset SHALL take priority over start and over any in-progress operation.
REQ-029 An operation aborted by reset SHALL never produce a done pulse.
REQ-030 The first edge with reset=0 SHALL be able to accept start.

Structure
REQ-031 The shared package SHALL hold the state enumeration (IDLE, ADD, DONE) and the constant SLICE_W = 4.
REQ-032 Exactly one sub-module SHALL be instantiated: the team's existing 4-bit ripple_adder, fed by the slice multiplexers.
REQ-033 No other adder logic SHALL exist in the block.
REQ-034 idx width SHALL be clog2(NIBBLES), with a minimum of 1.

Verification (NIBBLES=4)
REQ-035 A=0x1234, B=0x4321, Cin=0 -> S=0x5555, Cout=0, Ovf=0; done exactly 5 cycles after the start edge.
REQ-036 A=0xFFFF, B=0x0001, Cin=0 -> S=0x0000, Cout=1, Ovf=0 (carry crosses every slice boundary).
REQ-037 A=0x7FFF, B=0x0001 -> S=0x8000, Cout=0, Ovf=1; then A=0x8000, B=0x8000 -> S=0x0000, Cout=1, Ovf=1.
REQ-038 A=0x0000, B=0x0000, Cin=1 -> S=0x0001; in the same run, pulse start=1 with A=0xAAAA, B=0x5555 mid-ADD -> ignored, S stays 0x0001, a single done pulse.
REQ-039 Reset asserted on the second ADD edge -> busy=0, S=0, Cout=0, no done pulse; then start with 0x0F0F+0x00F1 -> S=0x1000.
REQ-040 Back-to-back: start held high continuously -> accepted every 6 cycles (IDLE, 4xADD, DONE), each result correct.
